pool_max_fp16_lanes: RTL and testbench
======================================

Name: pool_max_fp16_lanes

Overview:
- Multi-lane FP16 max-pooling accumulator for the conv datapath; generalises the single-lane max-pool unit.
- LANES independent channels share one window counter and one valid/ready handshake.
- Window length is programmable per window. The result is held until the consumer accepts it.
- Sits between the conv/ReLU output stage and the feature-map write-back buffer.

Parameters:
- LANES, 4: number of parallel FP16 channels.
- CNT_W, 8: width of the window-length field (max window 2^CNT_W-1 elements).
- DATA_W, 16: element width. Fixed at 16 (binary16); any other value is a static elaboration error.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- win_num  in  CNT_W  elements per window. Sampled only on the first accepted element of a window; 0 is treated as 1.
- in_valid  in  1  input element beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- in_data  in  LANES*DATA_W  lane i occupies bits [16i+15:16i].
- out_valid  out  1  pooled result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  LANES*DATA_W  per-lane max of the window.
- out_nan  out  LANES  per-lane flag: a NaN occurred in the window.
- busy  out  1  a window is partially accumulated.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_nan=0, busy=0, in_ready=1, internal count=0, state=IDLE.
- State IDLE:
  - in_ready=1.
  - On an accepted beat: acc<=in_data, nan<=isnan(in_data), len<=max(win_num,1), cnt<=1.
  - Next state is HOLD if len==1, else ACC.
- State ACC:
  - in_ready=1, busy=1.
  - On an accepted beat: acc_i<=max(acc_i,in_i), nan_i|=isnan(in_i), cnt<=cnt+1.
  - When cnt+1==len, next state is HOLD.
  - No beat means no change; gaps are allowed.
- State HOLD:
  - out_valid=1. out_data/out_nan are registered and stable until the handshake completes.
  - in_ready=out_ready, which gives a zero-bubble back-to-back window.
  - out_ready=1 with in_valid=1: the result retires and the same beat starts a new window, as in IDLE (win_num resampled).
  - out_ready=1 with in_valid=0: next state is IDLE.
  - out_ready=0: the state holds and input is stalled.
- Latency: out_valid rises the cycle after the last element of a window is accepted.
- Compare rule, per lane, combinational:
  - FP16 ordered compare by sign and magnitude.
  - -0 and +0 compare equal. On ties acc is kept, i.e. the earliest element wins.
  - Subnormals are compared exactly. No flush.
- NaN handling:
  - A NaN is exp=11111 with mant!=0.
  - NaN inputs never replace acc, and a NaN first element is replaced by the next non-NaN element.
  - An all-NaN window outputs 16'h7E00.
  - out_nan_i=1 whenever any NaN was seen in the window.
- Infinities compare normally: 7C00 beats everything non-NaN, FC00 loses to everything.
- win_num changes mid-window are ignored.
- rst mid-window or during HOLD discards the partial or held result the next cycle; no output is produced.
- The counter never wraps: len ≤ 2^CNT_W-1 and cnt stops at len.

Optional Feature:
- Macro POOL_RELU_EN.
- When defined, a fused ReLU is applied to each out_data lane: any negative non-NaN result (sign=1, including -0 and FC00) is output as 16'h0000. NaN output and out_nan are unchanged.
- When undefined, results are output unmodified.
- Timing is identical in both cases: the clamp sits on the registered output path, with no extra cycle.

Decomposition:
- Shared package/header CNN_Parameter.vh holds:
  - the FP16 constants FP16_POS_ZERO=16'h0000, FP16_QNAN=16'h7E00, FP16_POS_INF=16'h7C00, FP16_NEG_INF=16'hFC00;
  - the exponent all-ones field;
  - the state encodings IDLE/ACC/HOLD.
- One sub-module, fp16_max_cmp: two FP16 inputs, outputs max with NaN-skip and tie-keep-first. It is combinational and instantiated LANES times.

Test Plan:
- LANES=1, win_num=3, beats 4000,3C00,4700, out_ready=1 -> out_data=4700 one cycle after the third beat; out_nan=0.
- win_num=4, lane0 beats 4800,4000,4400,4200, lane1 beats C000,BC00,C400,8000 -> lane0 4800, lane1 8000. With POOL_RELU_EN, lane1 becomes 0000.
- Back-to-back, win_num=3:
  - beats 4000,4400,4200 then 3C00,3800,3A00 with continuous in_valid and out_ready=1;
  - expected results 4400 then 3C00;
  - in_ready is never low; the second window's first beat is accepted in the HOLD cycle.
- Backpressure:
  - window 4000,4700 (win_num=2), out_ready held 0 for 5 cycles;
  - out_valid=1 and out_data=4700 stay stable, in_ready=0 with no beat lost;
  - after out_ready=1 the next window is accepted.
- NaN and zero cases, win_num=3:
  - 7E01,3C00,7C01 -> 3C00 with out_nan=1;
  - 7E00,7E00,7E00 -> 7E00;
  - 8000,0000,8000 -> 8000 (tie keeps first).
- Corner cases:
  - win_num=0 with a single beat 4500 -> out_data=4500 next cycle;
  - rst=1 after 2 of 3 beats -> out_valid never asserts, busy=0 the next cycle, and the following window computes correctly.

Source files
------------

// File: rtl/pool_max_fp16_lanes_pkg.sv
// Shared FP16 constants, FSM state encoding and small FP16 helpers for the
// multi-lane max-pooling unit.
package pool_max_fp16_lanes_pkg;

    localparam logic [15:0] FP16_POS_ZERO = 16'h0000;
    localparam logic [15:0] FP16_QNAN     = 16'h7E00;
    localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
    localparam logic [15:0] FP16_NEG_INF  = 16'hFC00;
    localparam logic [4:0]  FP16_EXP_ONES = 5'h1F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic logic fp16_is_nan(input logic [15:0] x);
        return (x[14:10] == FP16_EXP_ONES) && (x[9:0] != 10'd0);
    endfunction

    // Monotonic unsigned key: larger key means larger FP16 value (NaN excluded).
    // Negative values are bit-inverted so larger magnitudes sort lower.
    function automatic logic [15:0] fp16_order_key(input logic [15:0] x);
        return x[15] ? ~x : {1'b1, x[14:0]};
    endfunction

    function automatic logic [15:0] fp16_relu(input logic [15:0] x);
        return (x[15] && !fp16_is_nan(x)) ? FP16_POS_ZERO : x;
    endfunction

endpackage

// File: rtl/pool_max_fp16_lanes_cmp.sv
// fp16_max_cmp: combinational FP16 max of an incumbent and a candidate.
// NaN candidates are skipped, a NaN incumbent is replaced, ties keep the incumbent.
module fp16_max_cmp
    import pool_max_fp16_lanes_pkg::*;
(
    input  logic [15:0] inc_in,
    input  logic [15:0] cand_in,
    output logic [15:0] max_out
);

    logic inc_nan;
    logic cand_nan;
    logic both_zero;
    logic cand_gt;

    assign inc_nan   = fp16_is_nan(inc_in);
    assign cand_nan  = fp16_is_nan(cand_in);
    // -0 and +0 have distinct keys, so equal zeros are filtered out explicitly.
    assign both_zero = (inc_in[14:0] == 15'd0) && (cand_in[14:0] == 15'd0);
    assign cand_gt   = !both_zero && (fp16_order_key(cand_in) > fp16_order_key(inc_in));

    always_comb begin
        max_out = inc_in;
        if (!cand_nan && (inc_nan || cand_gt)) begin
            max_out = cand_in;
        end
    end

endmodule

// File: rtl/pool_max_fp16_lanes.sv
// Multi-lane FP16 max-pooling accumulator with a shared window counter and
// valid/ready handshakes. Optional fused ReLU on the output when POOL_RELU_EN is defined.
module pool_max_fp16_lanes
    import pool_max_fp16_lanes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int CNT_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CNT_W-1:0]        win_num,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic [LANES-1:0]        out_nan,
    output logic                    busy
);

    generate
        if (DATA_W != 16) begin : g_bad_width
            $error("pool_max_fp16_lanes: DATA_W must be 16 (binary16)");
        end
    endgenerate

    state_t                  state_q, state_d;
    logic [LANES*DATA_W-1:0] acc_q, acc_d;
    logic [LANES-1:0]        nan_q, nan_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [LANES*DATA_W-1:0] in_canon;
    logic [LANES*DATA_W-1:0] cmp_max;
    logic [LANES-1:0]        in_nan;
    logic [CNT_W-1:0]        cnt_inc;
    logic [CNT_W-1:0]        win_len;
    logic                    start_win;
    logic                    step_win;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [DATA_W-1:0] lane_in;
            logic [DATA_W-1:0] lane_acc;

            assign lane_in  = in_data[gi*DATA_W +: DATA_W];
            assign lane_acc = acc_q[gi*DATA_W +: DATA_W];
            assign in_nan[gi] = fp16_is_nan(lane_in);
            // A NaN first element is stored as the canonical quiet NaN, so an
            // all-NaN window naturally emits 7E00.
            assign in_canon[gi*DATA_W +: DATA_W] = in_nan[gi] ? FP16_QNAN : lane_in;

            fp16_max_cmp u_cmp (
                .inc_in  (lane_acc),
                .cand_in (lane_in),
                .max_out (cmp_max[gi*DATA_W +: DATA_W])
            );

`ifdef POOL_RELU_EN
            assign out_data[gi*DATA_W +: DATA_W] = fp16_relu(lane_acc);
`else
            assign out_data[gi*DATA_W +: DATA_W] = lane_acc;
`endif
        end
    endgenerate

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign win_len = (win_num == '0) ? CNT_W'(1) : win_num;
    assign out_nan = nan_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        nan_d     = nan_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        start_win = 1'b0;
        step_win  = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready  = 1'b1;
                start_win = in_valid;
            end
            ACC: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                step_win = in_valid;
            end
            HOLD: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        start_win = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new window may start from IDLE or straight out of HOLD (zero bubble).
        if (start_win) begin
            acc_d   = in_canon;
            nan_d   = in_nan;
            len_d   = win_len;
            cnt_d   = CNT_W'(1);
            state_d = (win_len == CNT_W'(1)) ? HOLD : ACC;
        end

        if (step_win) begin
            acc_d = cmp_max;
            nan_d = nan_q | in_nan;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            nan_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            nan_q   <= nan_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_pool_max_fp16_lanes.sv
// Directed scoreboard bench for pool_max_fp16_lanes (two lanes).
module tb_pool_max_fp16_lanes;

    localparam int LANES  = 2;
    localparam int CNT_W  = 8;
    localparam int DATA_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [CNT_W-1:0]        win_num;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [LANES*DATA_W-1:0] out_data;
    logic [LANES-1:0]        out_nan;
    logic                    busy;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  nan;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_win    = 0;

    pool_max_fp16_lanes #(
        .LANES  (LANES),
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .win_num   (win_num),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_nan   (out_nan),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] relu_model(input logic [15:0] x);
        logic is_nan;
        is_nan = (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
`ifdef POOL_RELU_EN
        return (x[15] && !is_nan) ? 16'h0000 : x;
`else
        if (is_nan) return x;
        return x;
`endif
    endfunction

    task automatic push_exp(input logic [15:0] l1, input logic [15:0] l0, input logic [1:0] nan);
        exp_t e;
        e.data = {relu_model(l1), relu_model(l0)};
        e.nan  = nan;
        exp_q.push_back(e);
    endtask

    // Entered at a falling edge; returns at the falling edge after acceptance.
    task automatic beat(input logic [15:0] l1, input logic [15:0] l0,
                        input logic [CNT_W-1:0] w, output int stalls);
        logic ok;
        stalls   = 0;
        in_data  = {l1, l0};
        win_num  = w;
        in_valid = 1'b1;
        forever begin
            #1;
            ok = in_ready;
            @(negedge clk);
            if (ok) break;
            stalls++;
            if (stalls > 40) begin
                check("beat_accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Monitor: samples mid-cycle, after the driver has settled its inputs.
    always @(negedge clk) begin
        #2;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", out_data, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                n_win++;
                $display("window %0d: out_data=%h out_nan=%b (expected %h %b)",
                         n_win, out_data, out_nan, e.data, e.nan);
                check("out_data", out_data, e.data);
                check("out_nan", {30'd0, out_nan}, {30'd0, e.nan});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int st_sum;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        win_num   = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_nan", {30'd0, out_nan}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Basic window of 3 with latency check.
        push_exp(16'h0000, 16'h4700, 2'b00);
        beat(16'hC000, 16'h4000, 8'd3, st);
        beat(16'h0000, 16'h3C00, 8'd3, st);
        #1;
        check("basic_not_yet_valid", {31'd0, out_valid}, 32'd0);
        check("basic_busy", {31'd0, busy}, 32'd1);
        beat(16'hBC00, 16'h4700, 8'd3, st);
        #1;
        check("basic_valid_next_cycle", {31'd0, out_valid}, 32'd1);
        idle(2);

        // Window of 4, negative lane keeps -0 over larger-magnitude negatives.
        push_exp(16'h8000, 16'h4800, 2'b00);
        beat(16'hC000, 16'h4800, 8'd4, st);
        beat(16'hBC00, 16'h4000, 8'd4, st);
        beat(16'hC400, 16'h4400, 8'd4, st);
        beat(16'h8000, 16'h4200, 8'd4, st);
        idle(2);

        // Back-to-back windows, continuous in_valid.
        st_sum = 0;
        push_exp(16'h7C00, 16'h4400, 2'b00);
        beat(16'h7C00, 16'h4000, 8'd3, st); st_sum += st;
        beat(16'hFC00, 16'h4400, 8'd3, st); st_sum += st;
        beat(16'h0001, 16'h4200, 8'd3, st); st_sum += st;
        push_exp(16'hFC00, 16'h3C00, 2'b00);
        beat(16'hFC00, 16'h3C00, 8'd3, st); st_sum += st;
        beat(16'hFC00, 16'h3800, 8'd3, st); st_sum += st;
        beat(16'hFC00, 16'h3A00, 8'd3, st); st_sum += st;
        check("b2b_no_stalls", st_sum, 32'd0);
        idle(2);

        // Backpressure: result held, next beat stalled but not lost.
        out_ready = 1'b0;
        push_exp(16'h0002, 16'h4700, 2'b00);
        beat(16'h0001, 16'h4000, 8'd2, st);
        beat(16'h0002, 16'h4700, 8'd2, st);
        in_data  = {16'h8001, 16'h3C00};
        win_num  = 8'd1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_data", out_data, {16'h0002, 16'h4700});
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        push_exp(16'h8001, 16'h3C00, 2'b00);
        beat(16'h8001, 16'h3C00, 8'd1, st);
        check("bp_resume_no_stall", st, 32'd0);
        idle(2);

        // NaN handling and signed zero ties.
        push_exp(16'h7E00, 16'h3C00, 2'b11);
        beat(16'h7E00, 16'h7E01, 8'd3, st);
        beat(16'h7E00, 16'h3C00, 8'd3, st);
        beat(16'h7E00, 16'h7C01, 8'd3, st);
        idle(1);
        push_exp(16'hFC00, 16'h8000, 2'b10);
        beat(16'hFE00, 16'h8000, 8'd3, st);
        beat(16'hFC00, 16'h0000, 8'd3, st);
        beat(16'hFFFF, 16'h8000, 8'd3, st);
        idle(2);

        // win_num=0 behaves as a single-element window.
        push_exp(16'hC500, 16'h4500, 2'b00);
        beat(16'hC500, 16'h4500, 8'd0, st);
        #1;
        check("win0_valid_next_cycle", {31'd0, out_valid}, 32'd1);
        idle(2);

        // Reset mid-window discards the partial result.
        beat(16'h7BFF, 16'h4000, 8'd3, st);
        beat(16'h7BFF, 16'h4000, 8'd3, st);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        push_exp(16'h0401, 16'h3A00, 2'b00);
        beat(16'h0400, 16'h3800, 8'd3, st);
        beat(16'h03FF, 16'h3900, 8'd3, st);
        beat(16'h0401, 16'h3A00, 8'd3, st);
        idle(4);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
